cache_arbiter: RTL and testbench

// - Shares the single data-cache port between two requesters.
// - Port 0 is the CPU memory stage; port 1 is the program loader / debug DMA.
// - Accepts one request at a time and latches it.
// - Drives the cache until the access completes, then returns a registered done pulse and read data to the winner.
// - Round-robin arbitration by default, with an optional fixed-priority mode.

---
 rtl/cache_arbiter_pkg.sv | 15 +
 rtl/arb_rr_sel.sv | 18 +
 rtl/cache_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: FSM states and the latched request payload.
package cache_arbiter_pkg;

   localparam int unsigned REQ_ADDR_W = 32;
   localparam int unsigned REQ_DATA_W = 32;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/arb_rr_sel.sv
// Two-way requester picker: round-robin on ties, or port 0 always wins ties in fixed mode.
module arb_rr_sel #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant = valid;
      if (&valid) begin
         grant = (FIXED_PRIO || last_grant) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one data-cache port between the CPU memory stage (port 0) and the loader/debug DMA (port 1).
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [DATA_W-1:0] cache_wdata,
   input  logic [DATA_W-1:0] cache_rdata,
   output logic              cache_we,
   output logic              cache_re,
   input  logic              cache_miss,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t       state_q;
   arb_state_t       state_d;
   mem_req_t         req_q;
   mem_req_t         pick;
   logic             last_grant;
   logic [1:0]       grant;
   logic             accept;
   logic             complete;
   logic [CNT_W-1:0] wd_cnt;

   arb_rr_sel #(.FIXED_PRIO(FIXED_PRIO)) u_sel (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= ARB_IDLE;
      else       state_q <= state_d;
   end

   // Ready is held low during reset so nothing is accepted while the block is being cleared.
   always_comb begin
      state_d    = state_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      cache_re   = 1'b0;
      cache_we   = 1'b0;
      accept     = 1'b0;
      complete   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (rstn && (grant != 2'b00)) begin
               req0_ready = grant[0];
               req1_ready = grant[1];
               accept     = 1'b1;
               state_d    = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            cache_re = !req_q.we;
            cache_we = req_q.we;
            if (!cache_miss) begin
               complete = 1'b1;
               state_d  = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      pick = '{we: req0_we, addr: REQ_ADDR_W'(req0_addr), wdata: REQ_DATA_W'(req0_wdata)};
      if (grant[1]) begin
         pick = '{we: req1_we, addr: REQ_ADDR_W'(req1_addr), wdata: REQ_DATA_W'(req1_wdata)};
      end
   end

   // last_grant doubles as the id of the port that owns the access in flight.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_q      <= '0;
         last_grant <= 1'b1;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         req0_rdata <= '0;
         req1_rdata <= '0;
      end else begin
         req0_done <= complete && !last_grant;
         req1_done <= complete && last_grant;
         if (accept) begin
            req_q      <= pick;
            last_grant <= grant[1];
         end
         if (complete && !req_q.we) begin
            if (last_grant) req1_rdata <= cache_rdata;
            else            req0_rdata <= cache_rdata;
         end
      end
   end

   assign cache_addr  = ADDR_W'(req_q.addr);
   assign cache_wdata = DATA_W'(req_q.wdata);

   // Watchdog only flags a stuck access; the access itself keeps waiting.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else if (complete) begin
         wd_cnt <= '0;
      end else if ((state_q == ARB_BUSY) && cache_miss && (wd_cnt != CNT_W'(TIMEOUT))) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
         if (wd_cnt == CNT_W'(TIMEOUT - 1)) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter: arbitration, latency, watchdog, reset and back-to-back traffic.
module tb_cache_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_valid, req0_we, req1_valid, req1_we;
   logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic        req0_ready, req0_done, req1_ready, req1_done;
   logic [31:0] req0_rdata, req1_rdata;
   logic [31:0] cache_addr, cache_wdata, cache_rdata, rdata_drv;
   logic        cache_we, cache_re, cache_miss, err, mode;
   logic        fp_ready0, fp_done0, fp_ready1, fp_done1, fp_we, fp_re, fp_err;
   logic [31:0] fp_rdata0, fp_rdata1, fp_addr, fp_wdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign cache_rdata = mode ? (cache_addr ^ 32'hC0FFEE00) : rdata_drv;

   cache_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0), .TIMEOUT(8)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
      .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
      .cache_we(cache_we), .cache_re(cache_re), .cache_miss(cache_miss), .err(err)
   );

   cache_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1), .TIMEOUT(1024)) dut_fp (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(fp_ready0), .req0_done(fp_done0), .req0_rdata(fp_rdata0),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(fp_ready1), .req1_done(fp_done1), .req1_rdata(fp_rdata1),
      .cache_addr(fp_addr), .cache_wdata(fp_wdata), .cache_rdata(cache_rdata),
      .cache_we(fp_we), .cache_re(fp_re), .cache_miss(cache_miss), .err(fp_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      next();
      next();
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] q[$];
      int          issued, ndone, cyc;
      logic        exp_rdy, accepted;

      rstn = 1'b0; mode = 1'b0; cache_miss = 1'b0; rdata_drv = 32'hDEADBEEF;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0;     req1_wdata = '0;

      // Reset state, with a pending request that must not be accepted yet
      next(); next(); #1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_re",     cache_re, 0);
      chk("rst_we",     cache_we, 0);
      chk("rst_addr",   cache_addr, 0);
      chk("rst_done0",  req0_done, 0);
      chk("rst_rdata0", req0_rdata, 0);
      chk("rst_err",    err, 0);

      // Single read on port 0, no miss
      rstn = 1'b1; #1;
      chk("t1_ready0", req0_ready, 1);
      chk("t1_ready1", req1_ready, 0);
      next(); req0_valid = 1'b0; #1;
      chk("t1_re",    cache_re, 1);
      chk("t1_we",    cache_we, 0);
      chk("t1_addr",  cache_addr, 32'h100);
      chk("t1_busy_ready", req0_ready, 0);
      chk("t1_early_done", req0_done, 0);
      next(); #1;
      chk("t1_done0", req0_done, 1);
      chk("t1_rdata0", req0_rdata, 32'hDEADBEEF);
      chk("t1_re_off", cache_re, 0);
      next(); #1;
      chk("t1_done_pulse", req0_done, 0);

      // Both ports reading continuously: round-robin alternates, fixed priority always picks port 0
      do_reset();
      req0_valid = 1'b1; req0_addr = 32'h200;
      req1_valid = 1'b1; req1_addr = 32'h300;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready0", req0_ready, (i % 2) == 0);
         chk("rr_ready1", req1_ready, (i % 2) == 1);
         chk("fp_ready0", fp_ready0, 1);
         chk("fp_ready1", fp_ready1, 0);
         if (i > 0) begin
            if ((i % 2) == 1) chk("rr_rdata0", req0_rdata, 32'hA0 + 32'(i - 1));
            else              chk("rr_rdata1", req1_rdata, 32'hA0 + 32'(i - 1));
            chk("rr_done", ((i % 2) == 1) ? req0_done : req1_done, 1);
            chk("fp_done0",  fp_done0, 1);
            chk("fp_rdata0", fp_rdata0, 32'hA0 + 32'(i - 1));
         end
         next();
         rdata_drv = 32'hA0 + 32'(i); #1;
         chk("rr_addr", cache_addr, ((i % 2) == 0) ? 32'h200 : 32'h300);
         chk("rr_re",   cache_re, 1);
         chk("fp_addr", fp_addr, 32'h200);
         chk("fp_en",   {fp_re, fp_we}, 2'b10);
         next();
      end
      #1;
      chk("rr_done1_last", req1_done, 1);
      chk("rr_rdata1_last", req1_rdata, 32'hA3);
      chk("rr_rdata0_held", req0_rdata, 32'hA2);
      chk("fp_side", {fp_done1, fp_rdata1, fp_wdata, 31'(0), fp_err}, 64'h0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Port 1 write with three miss cycles
      next();
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h40; req1_wdata = 32'h12345678;
      cache_miss = 1'b1; rdata_drv = 32'hBAD0BAD0; #1;
      chk("wr_ready1", req1_ready, 1);
      chk("wr_ready0", req0_ready, 0);
      for (int c = 1; c <= 4; c++) begin
         next();
         req1_valid = 1'b0; cache_miss = (c < 4); #1;
         chk("wr_we",    cache_we, 1);
         chk("wr_re",    cache_re, 0);
         chk("wr_addr",  cache_addr, 32'h40);
         chk("wr_wdata", cache_wdata, 32'h12345678);
         chk("wr_early_done", req1_done, 0);
      end
      next(); #1;
      chk("wr_done1",  req1_done, 1);
      chk("wr_rdata1", req1_rdata, 32'hA3);
      chk("wr_we_off", cache_we, 0);
      chk("wr_err",    err, 0);

      // Watchdog: ten miss cycles against a limit of eight
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h80;
      cache_miss = 1'b1; rdata_drv = 32'h5A5A5A5A; #1;
      chk("wd_ready0", req0_ready, 1);
      for (int c = 1; c <= 10; c++) begin
         next();
         req0_valid = 1'b0; #1;
         chk("wd_err", err, c >= 9);
      end
      next();
      cache_miss = 1'b0; #1;
      chk("wd_re", cache_re, 1);
      next(); #1;
      chk("wd_done0",  req0_done, 1);
      chk("wd_rdata0", req0_rdata, 32'h5A5A5A5A);
      next(); #1;
      chk("wd_sticky", err, 1);

      // Reset in the second busy cycle of a missing read
      req0_valid = 1'b1; req0_addr = 32'h90; cache_miss = 1'b1; #1;
      chk("mr_ready0", req0_ready, 1);
      next();
      req0_valid = 1'b0;
      next(); #1;
      chk("mr_busy_re", cache_re, 1);
      rstn = 1'b0;
      next();
      cache_miss = 1'b0; #1;
      chk("mr_re",     cache_re, 0);
      chk("mr_we",     cache_we, 0);
      chk("mr_addr",   cache_addr, 0);
      chk("mr_err",    err, 0);
      chk("mr_dones",  {req0_done, req1_done}, 0);
      chk("mr_rdata0", req0_rdata, 0);
      next();
      rstn = 1'b1;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h44; rdata_drv = 32'h77; #1;
      chk("mr_no_done", req0_done, 0);
      chk("mr_ready1",  req1_ready, 1);
      next();
      req1_valid = 1'b0; #1;
      chk("mr_addr1", cache_addr, 32'h44);
      next(); #1;
      chk("mr_done1",  req1_done, 1);
      chk("mr_rdata1", req1_rdata, 32'h77);

      // Back-to-back port 0 reads, scoreboarded
      next();
      mode = 1'b1; req0_we = 1'b0; req0_addr = $urandom; req0_valid = 1'b1;
      issued = 0; ndone = 0; cyc = 0; exp_rdy = 1'b1;
      while ((issued < 100 || q.size() > 0) && cyc < 400) begin
         #1;
         if (req0_done) begin
            ndone++;
            chk("sb_outstanding", q.size() > 0, 1);
            if (q.size() > 0) chk("sb_rdata", req0_rdata, q.pop_front());
         end
         if (issued < 100) begin
            chk("b2b_ready", req0_ready, exp_rdy);
            exp_rdy = ~exp_rdy;
         end
         accepted = req0_ready;
         if (req0_ready) begin
            q.push_back(req0_addr ^ 32'hC0FFEE00);
            issued++;
         end
         next();
         cyc++;
         if (accepted) begin
            if (issued == 100) req0_valid = 1'b0;
            else               req0_addr  = $urandom;
         end
      end
      chk("sb_bound",  cyc < 400, 1);
      chk("sb_issued", issued, 100);
      chk("sb_done",   ndone, 100);
      chk("sb_done1",  req1_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
